regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 32, register count; DATA_WIDTH, 64, data bits; ADDR_WIDTH, $clog2(DEPTH), address bits; QDEPTH, 4, write-queue entries (power of two).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 alu_valid, alu_ppp[0:2], alu_addr[0:ADDR_WIDTH-1], alu_data[0:DATA_WIDTH-1]  input  ALU writeback request.
REQ-005 alu_ready  output  1  ALU request accepted on an edge where alu_valid and alu_ready are both 1.
REQ-006 mem_valid, mem_ppp[0:2], mem_addr[0:ADDR_WIDTH-1], mem_data[0:DATA_WIDTH-1]  input  load-unit writeback request.
REQ-007 mem_ready  output  1  load-unit accept, same rule as alu_ready.
REQ-008 wrEn, wrAddr[0:ADDR_WIDTH-1], dataIn[0:DATA_WIDTH-1], ppp[0:2]  output  register-file write port.
REQ-009 chk_addr0, chk_addr1 [0:ADDR_WIDTH-1]  input  decode-stage source addresses.
REQ-010 busy0, busy1  output  1  source has a queued, not yet issued write.
REQ-011 err_ppp  output  1  sticky flag for an accepted request with an illegal ppp.

Function
REQ-012 Queue SHALL be a QDEPTH-entry FIFO of {addr, ppp, data} with head/tail pointers and a count 0..QDEPTH.
REQ-013 Port readiness: full (count==QDEPTH) SHALL force alu_ready=mem_ready=0, with no same-cycle pop credit.
REQ-014 When not full and only one source is valid, that source's ready SHALL be 1.
REQ-015 When not full and both sources are valid, exactly one ready SHALL be 1, chosen by a round-robin pointer; the pointer SHALL toggle to the other source after each contested grant.
REQ-016 Legal ppp values SHALL be 000 (all), 001 (upper 32), 010 (lower 32), 011 (even bytes), 100 (odd bytes).
REQ-017 An accepted request with addr==0 or an illegal ppp SHALL be consumed but not enqueued.
REQ-018 An accepted request with an illegal ppp SHALL set err_ppp.
REQ-019 Issue: wrEn = (count!=0); wrAddr, ppp and dataIn SHALL come from the FIFO head entry, driven directly from storage registers.
REQ-020 The head SHALL pop on every edge where wrEn=1, since the register file accepts every cycle.
REQ-021 Latency: a request accepted at edge k into an empty queue SHALL give wrEn=1 during cycle k..k+1 and be written into the register file at edge k+1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged.
REQ-023 Pointers SHALL wrap modulo QDEPTH.
REQ-024 Write order SHALL equal accept order.
REQ-025 busyN SHALL be 1 iff chk_addrN!=0 and chk_addrN matches the addr of any occupied entry; this is combinational, and the head entry counts while wrEn=1.

Reset
REQ-026 While reset=0: count, head, tail and the round-robin pointer SHALL be 0 (ALU first); err_ppp=0.
REQ-027 While reset=0: wrEn=0, alu_ready=mem_ready=0, busy0=busy1=0.
REQ-028 FIFO data storage need not be reset; wrAddr, ppp and dataIn are don't-care while wrEn=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued writes immediately, with no write issued afterward.
REQ-030 Reset deassertion SHALL be synchronized by the integrator.

Structure
REQ-031 ppp encodings (aModePPP..oModePPP) and DEPTH/DATA_WIDTH defaults SHALL live in the shared regfile package used by the register file and this block.
REQ-032 The FIFO SHALL be a sub-module named wb_fifo (parameterized width/depth, push/pop/count); arbitration, filtering and scoreboard stay in regfile_wb_ctrl.

Verification
REQ-033 Single ALU write: addr 5, ppp 000, data 0x0123456789ABCDEF -> wrEn high next cycle with wrAddr 5; a connected register file reads R5=0x0123456789ABCDEF.
REQ-034 Contention: both sources valid for 4 cycles (ALU addrs 1-4, mem addrs 11-14) -> grants alternate ALU, mem, ALU, mem; issued order is 1,11,2,12.
REQ-035 Full: hold the register file side so four accepts occur back-to-back with no pop (force via wb_fifo stimulus) -> both readies 0 at count 4; on the next pop one accept resumes and no entry is lost.
REQ-036 Filtering: addr 0 with ppp 000, then addr 7 with ppp 110 -> both accepted, no wrEn for either, err_ppp=1 and stays 1 until reset.
REQ-037 Scoreboard: enqueue addr 9, chk_addr0=9 -> busy0=1 until the cycle after the write edge; chk_addr1=0 -> busy1=0 always.
REQ-038 Reset with 3 queued entries -> wrEn drops at once, count 0, and no further writes after deassertion.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl_pkg
//   Shared register-file definitions: default register count and data width,
//   the partial-write (ppp) encodings, the writeback arbiter's round-robin
//   state type and a legality helper for ppp codes.
//   Imported by the register file and by regfile_wb_ctrl.
// -----------------------------------------------------------------------------
package regfile_wb_ctrl_pkg;

   localparam int RF_DEPTH      = 32;
   localparam int RF_DATA_WIDTH = 64;
   localparam int PPP_WIDTH     = 3;

   // Partial-write selects understood by the register file
   typedef enum logic [PPP_WIDTH-1:0] {
      aModePPP = 3'b000,   // all 64 bits
      uModePPP = 3'b001,   // upper 32 bits
      lModePPP = 3'b010,   // lower 32 bits
      eModePPP = 3'b011,   // even bytes
      oModePPP = 3'b100    // odd bytes
   } ppp_e;

   // Which source wins the next contested cycle
   typedef enum logic {
      RR_ALU = 1'b0,
      RR_MEM = 1'b1
   } rr_e;

   // Encodings above oModePPP are unassigned
   function automatic logic ppp_legal(input logic [PPP_WIDTH-1:0] p);
      return (p <= PPP_WIDTH'(oModePPP));
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Small circular FIFO for queued register-file writes. Head/tail pointers
//   wrap modulo DEPTH (power of two); count runs 0..DEPTH. Storage is not
//   reset -- only the pointers and count are.
//   Besides the head entry it exposes, per slot, an occupancy bit and the top
//   TAG_W bits of the stored word so the owner can search queued entries.
//
//   Ports
//     clk, reset       clock, asynchronous active-low reset
//     push, push_data  write push_data at tail (ignored when full)
//     pop              drop head entry (ignored when empty)
//     head_data        oldest entry, straight from storage
//     count            number of occupied entries
//     occ              per-slot occupancy
//     tags             per-slot top TAG_W bits of stored word
// -----------------------------------------------------------------------------
module wb_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   parameter  int TAG_W = 1,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [CW-1:0]                count,
   output logic [DEPTH-1:0]             occ,
   output logic [DEPTH-1:0][TAG_W-1:0]  tags
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;
   logic [PW-1:0]    offs;

   assign do_pop  = pop  && (count_q != '0);
   assign do_push = push && (count_q != CW'(DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + PW'(1);
         if (do_pop)  head_q <= head_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= push_data;
   end

   assign head_data = mem_q[head_q];
   assign count     = count_q;

   // A slot is live when its distance from head (mod DEPTH) is below count
   always_comb begin
      occ  = '0;
      tags = '0;
      offs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs    = PW'(i) - head_q;
         occ[i]  = (CW'(offs) < count_q);
         tags[i] = mem_q[i][WIDTH-1 -: TAG_W];
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_wb_ctrl
//   Writeback controller in front of the register file. Two producers (ALU
//   and load unit) offer writes with a valid/ready handshake; a round-robin
//   arbiter grants one per cycle. Requests to r0 or with an unassigned ppp
//   are swallowed (the latter raises sticky err_ppp). Accepted writes queue in
//   wb_fifo and issue one per cycle from the head. busy0/busy1 tell decode
//   whether a source register still has a queued write.
//
//   Ports
//     clk, reset                         clock, async active-low reset
//     alu_valid/ppp/addr/data, alu_ready ALU writeback handshake
//     mem_valid/ppp/addr/data, mem_ready load-unit writeback handshake
//     wrEn, wrAddr, dataIn, ppp          register-file write port
//     chk_addr0/1, busy0/1               decode-stage pending-write lookup
//     err_ppp                            sticky illegal-ppp flag
// -----------------------------------------------------------------------------
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DEPTH      = RF_DEPTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int QDEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  alu_valid,
   input  logic [2:0]            alu_ppp,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,

   input  logic                  mem_valid,
   input  logic [2:0]            mem_ppp,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_ready,

   output logic                  wrEn,
   output logic [ADDR_WIDTH-1:0] wrAddr,
   output logic [DATA_WIDTH-1:0] dataIn,
   output logic [2:0]            ppp,

   input  logic [ADDR_WIDTH-1:0] chk_addr0,
   input  logic [ADDR_WIDTH-1:0] chk_addr1,
   output logic                  busy0,
   output logic                  busy1,

   output logic                  err_ppp
);

   localparam int EW = ADDR_WIDTH + PPP_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(QDEPTH + 1);

   logic                               full;
   logic                               contested;
   logic                               alu_acc;
   logic                               mem_acc;
   logic                               acc;
   logic                               sel_legal;
   logic                               push;
   logic                               fifo_pop;
   logic [ADDR_WIDTH-1:0]              sel_addr;
   logic [PPP_WIDTH-1:0]               sel_ppp;
   logic [DATA_WIDTH-1:0]              sel_data;
   logic [EW-1:0]                      head_entry;
   logic [CW-1:0]                      count;
   logic [QDEPTH-1:0]                  occ;
   logic [QDEPTH-1:0][ADDR_WIDTH-1:0]  q_addr;
   rr_e                                rr_q;

   // A full queue refuses both ports even if the head pops this cycle, so
   // readiness never depends on the register-file side.
   assign full      = (count == CW'(QDEPTH));
   assign contested = reset && !full && alu_valid && mem_valid;

   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (reset && !full) begin
         if (alu_valid && mem_valid) begin
            alu_ready = (rr_q == RR_ALU);
            mem_ready = (rr_q == RR_MEM);
         end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid;
         end
      end
   end

   // At most one port is granted, so a plain mux picks the accepted request
   assign alu_acc   = alu_valid && alu_ready;
   assign mem_acc   = mem_valid && mem_ready;
   assign acc       = alu_acc || mem_acc;
   assign sel_addr  = alu_acc ? alu_addr : mem_addr;
   assign sel_ppp   = alu_acc ? alu_ppp  : mem_ppp;
   assign sel_data  = alu_acc ? alu_data : mem_data;
   assign sel_legal = ppp_legal(sel_ppp);

   // r0 is hardwired and bad ppp codes are dropped: handshake completes,
   // nothing is queued
   assign push = acc && sel_legal && (sel_addr != '0);

   // Arbiter pointer and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q    <= RR_ALU;
         err_ppp <= 1'b0;
      end else begin
         if (contested) rr_q <= (rr_q == RR_ALU) ? RR_MEM : RR_ALU;
         if (acc && !sel_legal) err_ppp <= 1'b1;
      end
   end

   wb_fifo #(
      .WIDTH (EW),
      .DEPTH (QDEPTH),
      .TAG_W (ADDR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({sel_addr, sel_ppp, sel_data}),
      .pop       (fifo_pop),
      .head_data (head_entry),
      .count     (count),
      .occ       (occ),
      .tags      (q_addr)
   );

   // The register file takes a write every cycle, so the head always pops
   assign wrEn     = reset && (count != '0);
   assign fifo_pop = wrEn;
   assign {wrAddr, ppp, dataIn} = head_entry;

   // Pending-write lookup; the issuing head is still occupied, so it counts
   always_comb begin
      busy0 = 1'b0;
      busy1 = 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (occ[i] && (q_addr[i] == chk_addr0)) busy0 = 1'b1;
         if (occ[i] && (q_addr[i] == chk_addr1)) busy1 = 1'b1;
      end
      if (!reset || (chk_addr0 == '0)) busy0 = 1'b0;
      if (!reset || (chk_addr1 == '0)) busy1 = 1'b0;
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
   import regfile_wb_ctrl_pkg::*;

   localparam int AW = 5;
   localparam int DW = 64;

   logic          clk;
   logic          reset;
   logic          alu_valid, mem_valid;
   logic [2:0]    alu_ppp, mem_ppp, ppp;
   logic [AW-1:0] alu_addr, mem_addr, wrAddr, chk_addr0, chk_addr1;
   logic [DW-1:0] alu_data, mem_data, dataIn;
   logic          alu_ready, mem_ready, wrEn, busy0, busy1, err_ppp;

   int            n_vec = 0;
   int            n_err = 0;
   logic          hold  = 1'b0;

   logic [AW-1:0] wl_addr[$];
   logic [DW-1:0] wl_data[$];
   logic [2:0]    wl_ppp[$];
   logic [DW-1:0] rf [32];

   regfile_wb_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_ppp   (alu_ppp),
      .alu_addr  (alu_addr),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_ppp   (mem_ppp),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .wrEn      (wrEn),
      .wrAddr    (wrAddr),
      .dataIn    (dataIn),
      .ppp       (ppp),
      .chk_addr0 (chk_addr0),
      .chk_addr1 (chk_addr1),
      .busy0     (busy0),
      .busy1     (busy1),
      .err_ppp   (err_ppp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: the write issued in a cycle lands at the next edge
   always @(negedge clk) begin
      if (wrEn === 1'b1 && !hold) begin
         wl_addr.push_back(wrAddr);
         wl_data.push_back(dataIn);
         wl_ppp.push_back(ppp);
         rf[wrAddr] <= dataIn;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wl_addr.delete();
      wl_data.delete();
      wl_ppp.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ai;
      int mi;
      logic [AW-1:0] exp_ord [4];
      exp_ord[0] = 5'd1; exp_ord[1] = 5'd11; exp_ord[2] = 5'd2; exp_ord[3] = 5'd12;

      // ---------------- reset state ----------------
      reset     = 1'b0;
      alu_valid = 1'b1; alu_ppp = 3'b000; alu_addr = 5'd3; alu_data = 64'h1;
      mem_valid = 1'b1; mem_ppp = 3'b000; mem_addr = 5'd4; mem_data = 64'h2;
      chk_addr0 = 5'd3; chk_addr1 = 5'd4;
      repeat (3) cyc();
      chk("rst_wrEn",      64'(wrEn),      64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      chk("rst_busy0",     64'(busy0),     64'd0);
      chk("rst_busy1",     64'(busy1),     64'd0);
      chk("rst_err",       64'(err_ppp),   64'd0);
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk_addr0 = 5'd0; chk_addr1 = 5'd0;
      reset = 1'b1;
      cyc();

      // ---------------- single ALU write ----------------
      clear_log();
      alu_valid = 1'b1; alu_addr = 5'd5; alu_ppp = 3'b000; alu_data = 64'h0123456789ABCDEF;
      #1;
      chk("t1_alu_ready", 64'(alu_ready), 64'd1);
      cyc();
      alu_valid = 1'b0;
      #1;
      chk("t1_wrEn",   64'(wrEn),   64'd1);
      chk("t1_wrAddr", 64'(wrAddr), 64'd5);
      chk("t1_dataIn", dataIn,      64'h0123456789ABCDEF);
      chk("t1_ppp",    64'(ppp),    64'd0);
      cyc();
      chk("t1_wrEn_off", 64'(wrEn),           64'd0);
      chk("t1_R5",       rf[5],               64'h0123456789ABCDEF);
      chk("t1_nwrites",  64'(wl_addr.size()), 64'd1);

      // ---------------- contention ----------------
      clear_log();
      ai = 0; mi = 0;
      for (int c = 0; c < 4; c++) begin
         alu_addr = AW'(1 + ai);  alu_data = 64'h100 + 64'(ai); alu_ppp = 3'b000; alu_valid = 1'b1;
         mem_addr = AW'(11 + mi); mem_data = 64'h200 + 64'(mi); mem_ppp = 3'b010; mem_valid = 1'b1;
         #1;
         chk($sformatf("t2_grant%0d", c), 64'({alu_ready, mem_ready}),
             (c % 2 == 0) ? 64'd2 : 64'd1);
         if (alu_ready) ai++;
         if (mem_ready) mi++;
         cyc();
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      repeat (2) cyc();
      chk("t2_nwrites", 64'(wl_addr.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wl_addr.size())
            chk($sformatf("t2_order%0d", i), 64'(wl_addr[i]), 64'(exp_ord[i]));
      end
      if (wl_data.size() > 1) chk("t2_data1", wl_data[1], 64'h200);

      // ---------------- full queue ----------------
      clear_log();
      force dut.fifo_pop = 1'b0;
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_addr = AW'(20 + i); alu_data = 64'hF00 + 64'(i);
         alu_ppp = (i == 1) ? 3'b100 : 3'b000;
         #1;
         chk($sformatf("t3_fill%0d", i), 64'(alu_ready), 64'd1);
         cyc();
      end
      alu_addr = 5'd24; alu_data = 64'hF04; alu_ppp = 3'b011;
      mem_valid = 1'b1; mem_addr = 5'd25; mem_ppp = 3'b000;
      chk_addr1 = 5'd22;
      #1;
      chk("t3_count4",    64'(dut.count), 64'd4);
      chk("t3_alu_full",  64'(alu_ready), 64'd0);
      chk("t3_mem_full",  64'(mem_ready), 64'd0);
      chk("t3_busy1",     64'(busy1),     64'd1);
      release dut.fifo_pop;
      hold = 1'b0;
      mem_valid = 1'b0;
      chk_addr1 = 5'd0;
      #1;
      chk("t3_no_credit", 64'(alu_ready), 64'd0);
      cyc();
      chk("t3_resume", 64'(alu_ready), 64'd1);
      cyc();
      alu_valid = 1'b0;
      repeat (5) cyc();
      chk("t3_nwrites", 64'(wl_addr.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < wl_addr.size()) begin
            chk($sformatf("t3_addr%0d", i), 64'(wl_addr[i]), 64'(20 + i));
            chk($sformatf("t3_data%0d", i), wl_data[i], 64'hF00 + 64'(i));
         end
      end
      if (wl_ppp.size() > 4) begin
         chk("t3_ppp_odd",  64'(wl_ppp[1]), 64'd4);
         chk("t3_ppp_even", 64'(wl_ppp[4]), 64'd3);
      end

      // ---------------- filtering ----------------
      clear_log();
      alu_valid = 1'b1; alu_addr = 5'd0; alu_ppp = 3'b000; alu_data = 64'hDEAD;
      #1;
      chk("t4_r0_ready", 64'(alu_ready), 64'd1);
      cyc();
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_addr = 5'd7; mem_ppp = 3'b110; mem_data = 64'hBEEF;
      #1;
      chk("t4_r0_wrEn",   64'(wrEn),      64'd0);
      chk("t4_r0_err",    64'(err_ppp),   64'd0);
      chk("t4_bad_ready", 64'(mem_ready), 64'd1);
      cyc();
      mem_valid = 1'b0;
      #1;
      chk("t4_bad_wrEn", 64'(wrEn),    64'd0);
      chk("t4_bad_err",  64'(err_ppp), 64'd1);
      repeat (4) cyc();
      chk("t4_err_sticky", 64'(err_ppp),          64'd1);
      chk("t4_nwrites",    64'(wl_addr.size()),   64'd0);

      // ---------------- scoreboard ----------------
      clear_log();
      chk_addr0 = 5'd9; chk_addr1 = 5'd0;
      mem_valid = 1'b1; mem_addr = 5'd9; mem_ppp = 3'b001; mem_data = 64'h99;
      #1;
      chk("t5_busy0_pre", 64'(busy0), 64'd0);
      cyc();
      mem_valid = 1'b0;
      #1;
      chk("t5_busy0_q",  64'(busy0), 64'd1);
      chk("t5_busy1_q",  64'(busy1), 64'd0);
      cyc();
      chk("t5_busy0_wr", 64'(busy0), 64'd0);
      chk("t5_busy1_wr", 64'(busy1), 64'd0);
      chk("t5_waddr",    (wl_addr.size() == 1) ? 64'(wl_addr[0]) : 64'hFFFF, 64'd9);
      chk_addr0 = 5'd0;

      // ---------------- reset mid-operation ----------------
      clear_log();
      force dut.fifo_pop = 1'b0;
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_addr = (i == 2) ? 5'd2 : AW'(30 + i); alu_ppp = 3'b000;
         alu_data = 64'hAB0 + 64'(i);
         cyc();
      end
      alu_valid = 1'b0;
      #1;
      chk("t6_count3", 64'(dut.count), 64'd3);
      reset = 1'b0;
      release dut.fifo_pop;
      hold = 1'b0;
      #1;
      chk("t6_wrEn_drop", 64'(wrEn),       64'd0);
      chk("t6_count0",    64'(dut.count),  64'd0);
      chk("t6_err_clr",   64'(err_ppp),    64'd0);
      repeat (2) cyc();
      reset = 1'b1;
      repeat (5) cyc();
      chk("t6_wrEn_after", 64'(wrEn),            64'd0);
      chk("t6_nwrites",    64'(wl_addr.size()),  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
